// File: rtl/seg7_scan_controller_if.sv
// Bundles the display-side signals of seg7_scan_controller.
//
// Handshake: LOAD is a one-cycle strobe with no back-pressure. Every LOAD
// is accepted, and a newer LOAD replaces older data that is still pending.
// BUSY is status only. It reads 1 while captured data is waiting for the
// next frame boundary to become visible.
//
// Signals (direction seen from the controller, i.e. the slave modport):
//   DIGITS   in  4*NUM_DIGITS  hex nibble per digit, digit 0 in [3:0]
//   DP_IN    in  NUM_DIGITS    decimal point on, per digit
//   BLANK_IN in  NUM_DIGITS    force digit dark, per digit
//   BLINK_IN in  NUM_DIGITS    blink enable, per digit
//   BRIGHT   in  4             duty level 0..15
//   LOAD     in  1             capture strobe for the four fields above
//   BUSY     out 1             captured data not yet displayed
//   segs     out 7             active-low segments, bit6=a .. bit0=g
//   dp       out 1             active-low decimal point
//   an       out NUM_DIGITS    active-low anodes, an[i] drives digit i
interface seg7_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] DIGITS;
  logic [NUM_DIGITS-1:0]   DP_IN;
  logic [NUM_DIGITS-1:0]   BLANK_IN;
  logic [NUM_DIGITS-1:0]   BLINK_IN;
  logic [3:0]              BRIGHT;
  logic                    LOAD;
  logic                    BUSY;
  logic [6:0]              segs;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;

  modport master (
    output DIGITS, DP_IN, BLANK_IN, BLINK_IN, BRIGHT, LOAD,
    input  BUSY, segs, dp, an
  );

  modport slave (
    input  DIGITS, DP_IN, BLANK_IN, BLINK_IN, BRIGHT, LOAD,
    output BUSY, segs, dp, an
  );
endinterface

// File: rtl/seg7_scan_controller.sv
// Multiplexed 7-segment scan controller with per-digit blank, blink and
// decimal point, plus 16-step brightness.
//
// The design uses one clock domain. A slot counter divides each digit
// slot into 16 sub-periods. An anode is lit only in sub-periods
// s <= BRIGHT. New data goes into pending registers on LOAD. It moves to
// the active registers only at a frame boundary, so each frame is drawn
// from a single data set.
//
// Ports:
//   CLK    system clock
//   RESET  asynchronous, active-high reset
//   bus    seg7_scan_controller_if.slave (data in, BUSY/segs/dp/an out)
module seg7_scan_controller #(
  parameter int CLK_FREQ     = 100000000,
  parameter int SCAN_FREQ    = 1000,
  parameter int NUM_DIGITS   = 4,
  parameter int BLINK_FRAMES = 250
) (
  input logic                    CLK,
  input logic                    RESET,
  seg7_scan_controller_if.slave  bus
);

  localparam int SLOT_TICKS = CLK_FREQ / (SCAN_FREQ * NUM_DIGITS);
  localparam int SUB        = SLOT_TICKS / 16;
  localparam int SW         = $clog2(SLOT_TICKS);
  localparam int DW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  if (SLOT_TICKS < 16) begin : g_slot_check
    $error("seg7_scan_controller: SLOT_TICKS must be at least 16");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_digit_check
    $error("seg7_scan_controller: NUM_DIGITS must be 1..8");
  end

  // Scan timing state
  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          phase_q, phase_d;

  // Pending and active display data
  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d, act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]   pend_blink_q, pend_blink_d, act_blink_q, act_blink_d;
  logic                    busy_q, busy_d;

  // Registered outputs
  logic [6:0]            segs_q, segs_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic          slot_end, last_dig, frame_end;
  logic [SW-1:0] sub_raw;
  logic [3:0]    sub_idx;
  logic [3:0]    nibble;
  logic          cur_on;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h01;
      4'h1: glyph = 7'h4F;
      4'h2: glyph = 7'h12;
      4'h3: glyph = 7'h06;
      4'h4: glyph = 7'h4C;
      4'h5: glyph = 7'h24;
      4'h6: glyph = 7'h20;
      4'h7: glyph = 7'h0F;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h04;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h60;
      4'hC: glyph = 7'h31;
      4'hD: glyph = 7'h42;
      4'hE: glyph = 7'h30;
      default: glyph = 7'h38;
    endcase
  endfunction

  assign slot_end  = (slot_cnt_q == SW'(SLOT_TICKS - 1));
  assign last_dig  = (dig_q == DW'(NUM_DIGITS - 1));
  assign frame_end = slot_end && last_dig;

  // If SLOT_TICKS is not a multiple of 16, the leftover clocks at the end of
  // a slot stay in sub-period 15.
  assign sub_raw = slot_cnt_q / SW'(SUB);
  assign sub_idx = (sub_raw > SW'(15)) ? 4'd15 : sub_raw[3:0];

  // Next-state for the counters and the data registers
  always_comb begin
    slot_cnt_d   = slot_end ? '0 : slot_cnt_q + 1'b1;
    dig_d        = dig_q;
    frame_cnt_d  = frame_cnt_q;
    phase_d      = phase_q;
    pend_dig_d   = pend_dig_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_blink_d = pend_blink_q;
    act_dig_d    = act_dig_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    act_blink_d  = act_blink_q;
    busy_d       = busy_q;

    if (slot_end) begin
      dig_d = last_dig ? '0 : dig_q + 1'b1;
    end

    if (frame_end) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    // Commit first. A LOAD in the same cycle then refills pending and keeps
    // BUSY set, so its data appears at the following boundary.
    if (frame_end && busy_q) begin
      act_dig_d   = pend_dig_q;
      act_dp_d    = pend_dp_q;
      act_blank_d = pend_blank_q;
      act_blink_d = pend_blink_q;
      busy_d      = 1'b0;
    end

    if (bus.LOAD) begin
      pend_dig_d   = bus.DIGITS;
      pend_dp_d    = bus.DP_IN;
      pend_blank_d = bus.BLANK_IN;
      pend_blink_d = bus.BLINK_IN;
      busy_d       = 1'b1;
    end
  end

  // Output decode from the current digit index and sub-period
  always_comb begin
    nibble = act_dig_q[dig_q*4 +: 4];
    cur_on = (sub_idx <= bus.BRIGHT) && !act_blank_q[dig_q] &&
             !(phase_q && act_blink_q[dig_q]);
    an_d   = cur_on ? ~(NUM_DIGITS'(1) << dig_q) : '1;
    segs_d = cur_on ? glyph(nibble) : 7'h7F;
    dp_d   = !(cur_on && act_dp_q[dig_q]);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      slot_cnt_q   <= '0;
      dig_q        <= '0;
      frame_cnt_q  <= '0;
      phase_q      <= 1'b0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_blink_q <= '0;
      act_dig_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      act_blink_q  <= '0;
      busy_q       <= 1'b0;
      segs_q       <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      dig_q        <= dig_d;
      frame_cnt_q  <= frame_cnt_d;
      phase_q      <= phase_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_blink_q <= pend_blink_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      act_blink_q  <= act_blink_d;
      busy_q       <= busy_d;
      segs_q       <= segs_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.segs = segs_q;
  assign bus.dp   = dp_q;
  assign bus.an   = an_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Bench for seg7_scan_controller. The configuration gives 16 clocks per
// slot, 64 clocks per frame, and blink half-period of 2 frames.
module tb_seg7_scan_controller;

  localparam int CLK_FREQ  = 6400;
  localparam int SCAN_FREQ = 100;
  localparam int ND        = 4;
  localparam int BLINK     = 2;
  localparam int SLOT      = CLK_FREQ / (SCAN_FREQ * ND);
  localparam int SUBT      = SLOT / 16;
  localparam int FRAME     = SLOT * ND;
  localparam int W         = ND + 7 + 1 + 1;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_controller_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_controller #(
    .CLK_FREQ    (CLK_FREQ),
    .SCAN_FREQ   (SCAN_FREQ),
    .NUM_DIGITS  (ND),
    .BLINK_FRAMES(BLINK)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  logic [6:0] glyph [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  // Reference model state: t counts clocks since reset release
  int            t;
  logic [4*ND-1:0] m_pd, m_ad;
  logic [ND-1:0] m_pdp, m_adp, m_pbl, m_abl, m_pbk, m_abk;
  bit            m_busy;
  bit            rand_bright;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h expected=%h", name, t, got, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_pd = '0; m_ad = '0;
    m_pdp = '0; m_adp = '0; m_pbl = '0; m_abl = '0; m_pbk = '0; m_abk = '0;
    m_busy = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_an",   32'(bus.an),   32'hF);
    check("rst_segs", 32'(bus.segs), 32'h7F);
    check("rst_dp",   32'(bus.dp),   32'h1);
    check("rst_busy", 32'(bus.BUSY), 32'h0);
  endtask

  // Called at a negedge. It drives the inputs for the next posedge,
  // predicts the outputs after that edge, then waits for the following
  // negedge.
  task automatic step(input bit ld);
    int p, dig, s, frame;
    bit phase, on;
    logic [ND-1:0] an_e;
    logic [6:0]    seg_e;
    logic          dp_e;
    if (!ld) begin
      bus.DIGITS   = 16'($urandom());
      bus.DP_IN    = 4'($urandom());
      bus.BLANK_IN = 4'($urandom());
      bus.BLINK_IN = 4'($urandom());
    end
    if (rand_bright) bus.BRIGHT = 4'($urandom_range(0, 15));
    bus.LOAD = ld;

    p     = t % FRAME;
    dig   = p / SLOT;
    s     = (p % SLOT) / SUBT;
    if (s > 15) s = 15;
    frame = t / FRAME;
    phase = ((frame / BLINK) % 2) == 1;
    on    = (s <= int'(bus.BRIGHT)) && !m_abl[dig] && !(phase && m_abk[dig]);
    an_e  = on ? ~(ND'(1) << dig) : '1;
    seg_e = on ? glyph[m_ad[dig*4 +: 4]] : 7'h7F;
    dp_e  = !(on && m_adp[dig]);

    if (p == FRAME - 1 && m_busy) begin
      m_ad = m_pd; m_adp = m_pdp; m_abl = m_pbl; m_abk = m_pbk;
      m_busy = 1'b0;
    end
    if (ld) begin
      m_pd = bus.DIGITS; m_pdp = bus.DP_IN; m_pbl = bus.BLANK_IN; m_pbk = bus.BLINK_IN;
      m_busy = 1'b1;
    end
    t++;
    exp_q.push_back({an_e, seg_e, dp_e, m_busy});
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic do_load(input logic [4*ND-1:0] d, input logic [ND-1:0] dp,
                         input logic [ND-1:0] bl, input logic [ND-1:0] bk);
    bus.DIGITS = d; bus.DP_IN = dp; bus.BLANK_IN = bl; bus.BLINK_IN = bk;
    step(1'b1);
  endtask

  // Monitor: compares every cycle's outputs against the queued prediction
  logic [W-1:0] mon_exp;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("out{an,segs,dp,busy}", 32'({bus.an, bus.segs, bus.dp, bus.BUSY}), 32'(mon_exp));
        check("an_onehot", 32'($countones(~bus.an) <= 1), 32'h1);
      end
    end
  end

  // Stimulus
  initial begin
    rand_bright  = 1'b0;
    bus.LOAD     = 1'b0;
    bus.DIGITS   = '0;
    bus.DP_IN    = '0;
    bus.BLANK_IN = '0;
    bus.BLINK_IN = '0;
    bus.BRIGHT   = 4'd15;
    model_reset();

    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Digits show 0 at full brightness until the first commit
    run(2 * FRAME);

    // Load mid-frame; it commits at the next boundary
    run(20);
    do_load(16'hA5C3, 4'b0000, 4'b0000, 4'b0000);
    run(2 * FRAME);

    // Reduced duty
    bus.BRIGHT = 4'd3;
    run(FRAME);
    bus.BRIGHT = 4'd15;

    // Blank digit 1, decimal point on digit 0
    do_load(16'h0123, 4'b0001, 4'b0010, 4'b0000);
    run(2 * FRAME);

    // Blink digit 3 across several blink periods
    do_load(16'h89AB, 4'b0000, 4'b0000, 4'b1000);
    run(9 * FRAME);

    // A pending load, then a second load on the exact boundary cycle
    run((FRAME + 30 - (t % FRAME)) % FRAME);
    do_load(16'h4567, 4'b0100, 4'b0000, 4'b0000);
    run(FRAME - 1 - (t % FRAME));
    do_load(16'hCDEF, 4'b1000, 4'b0001, 4'b0000);
    run(2 * FRAME);

    // Random traffic, including back-to-back overwrites
    rand_bright = 1'b1;
    for (int i = 0; i < 12; i++) begin
      run($urandom_range(1, 150));
      do_load(16'($urandom()), 4'($urandom()), 4'($urandom()), 4'($urandom()));
      if (i % 4 == 0) do_load(16'($urandom()), 4'($urandom()), 4'($urandom()), 4'($urandom()));
    end
    run(2 * FRAME);

    // Mid-slot reset while a load is pending
    rand_bright = 1'b0;
    bus.BRIGHT  = 4'd15;
    run(10);
    do_load(16'hFFFF, 4'b1111, 4'b0000, 4'b0000);
    run(5);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(2 * FRAME);

    @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_controller.md
SEG7_SCAN_CONTROLLER -- requirements
Module: seg7_scan_controller

Interface
REQ-001 The module SHALL have parameter CLK_FREQ, default 100000000, meaning input clock frequency in Hz.
REQ-002 The module SHALL have parameter SCAN_FREQ, default 1000, meaning full-frame refresh rate in Hz.
REQ-003 The module SHALL have parameter NUM_DIGITS, default 4, legal range 1..8, meaning number of multiplexed digits.
REQ-004 The module SHALL have parameter BLINK_FRAMES, default 250, meaning frames per blink half-period.
REQ-005 The module SHALL have port CLK, input, 1 bit, meaning the single system clock; no derived clocks are used.
REQ-006 The module SHALL have port RESET, input, 1 bit, meaning the asynchronous, active-high reset.
REQ-007 The module SHALL have port DIGITS, input, 4*NUM_DIGITS bits, meaning the hex nibble per digit; digit 0 is bits [3:0].
REQ-008 The module SHALL have ports DP_IN, BLANK_IN and BLINK_IN, each input, NUM_DIGITS bits, meaning per-digit decimal point on, force-off and blink enable.
REQ-009 The module SHALL have port BRIGHT, input, 4 bits, meaning duty level 0..15.
REQ-010 The module SHALL have port LOAD, input, 1 bit, meaning a single-cycle strobe that captures DIGITS, DP_IN, BLANK_IN and BLINK_IN.
REQ-011 The module SHALL have port BUSY, output, 1 bit, meaning that captured data is pending and not yet displayed.
REQ-012 The module SHALL have port segs, output, 7 bits, meaning active-low segments with bit6=a through bit0=g.
REQ-013 The module SHALL have port dp, output, 1 bit, meaning the active-low decimal point.
REQ-014 The module SHALL have port an, output, NUM_DIGITS bits, meaning active-low anodes; an[i] drives digit i.

Function
REQ-015 Timing SHALL derive from a CLK-domain tick counter with SLOT_TICKS = CLK_FREQ/(SCAN_FREQ*NUM_DIGITS) clocks per digit slot; SUB = SLOT_TICKS/16, with SLOT_TICKS >= 16 enforced by elaboration check.
REQ-016 The digit index SHALL advance 0,1,..,NUM_DIGITS-1 and wrap to 0 at each slot end; the cycle in which the index wraps to 0 is the frame boundary.
REQ-017 The sub-period index s (0..15) SHALL equal slot counter / SUB; the anode of the current digit SHALL be active only while s <= BRIGHT, so BRIGHT=15 gives full on and BRIGHT=0 gives 1/16 duty; BRIGHT is sampled each clock.
REQ-018 LOAD=1 SHALL copy all inputs into pending registers and set BUSY the next cycle; a repeated LOAD before commit SHALL overwrite the pending data.
REQ-019 At each frame boundary with BUSY=1, pending SHALL be copied to active registers and BUSY cleared the same cycle; the display never mixes old and new data within a frame.
REQ-020 If LOAD coincides with a frame boundary, the newly presented data SHALL be written to pending and BUSY SHALL remain 1, to commit at the next boundary.
REQ-021 A frame counter SHALL toggle blink phase every BLINK_FRAMES frames; when phase=1, digits with active BLINK bit SHALL be dark (anode off).
REQ-022 A digit with active BLANK bit SHALL keep its anode off in all sub-periods.
REQ-023 The glyph encoding SHALL be as follows, in hex: 0:01 1:4F 2:12 3:06 4:4C 5:24 6:20 7:0F 8:00 9:04 A:08 b:60 C:31 d:42 E:30 F:38.
REQ-024 dp SHALL be 0 when the current digit's active DP bit is 1 and its anode is on, and 1 otherwise.
REQ-025 segs, dp and an SHALL be registered with one clock latency from the index and sub-period state; at most one an bit SHALL be 0 at any time.

Reset
REQ-026 While RESET=1, all counters, the digit index, blink phase, active and pending registers and BUSY SHALL be 0, with an=all 1s, segs=7'h7F and dp=1.
REQ-027 After RESET is released, scanning SHALL start at digit 0, slot counter 0, with all digits showing 0 until the first commit.
REQ-028 RESET asserted mid-frame or with BUSY=1 SHALL discard pending data.

Verification
REQ-029 Test: Use CLK_FREQ=6400, SCAN_FREQ=100, NUM_DIGITS=4 (SLOT_TICKS=16, SUB=1) and apply BRIGHT=15 -> each an bit is low for 16 clocks, in order 0..3, with no overlap.
REQ-030 Test: LOAD DIGITS=16'hA5C3 mid-frame -> BUSY=1 until the next frame boundary; digit 0 then shows 7'h06, digit 1 7'h31, digit 2 7'h24 and digit 3 7'h08.
REQ-031 Test: Apply BRIGHT=3 -> each anode is low for exactly 4 of 16 slot clocks (s=0..3).
REQ-032 Test: Apply BLANK_IN=4'b0010 and DP_IN=4'b0001 -> an[1] never goes low, and dp=0 only while an[0]=0.
REQ-033 Test: Use BLINK_FRAMES=2 with BLINK_IN=4'b1000 -> digit 3 is dark for 2 frames and lit for 2 frames, alternating.
REQ-034 Test: Assert RESET for 1 clock mid-slot with BUSY=1 -> outputs go to their reset values asynchronously, BUSY=0, and the old data is not displayed.
